// File: rtl/dm_load_reader.sv
// MEM-stage load reader: samples the data-memory word on accept and presents the extended result to WB one cycle later.
// Optional misaligned-load exception reporting is enabled by defining DM_LOAD_ADDR_EXC_EN.
module dm_load_reader #(
  parameter int unsigned AW     = 12,
  parameter logic [31:0] RST_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_type,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_pc,
  output logic [AW-1:0] mem_A,
  input  logic [31:0]   mem_RData,
  input  logic          wb_stall,
  input  logic          flush,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic [31:0]   rsp_pc,
  output logic          rsp_exc
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [2:0] T_LBU = 3'd1;
  localparam logic [2:0] T_LB  = 3'd2;
  localparam logic [2:0] T_LHU = 3'd3;
  localparam logic [2:0] T_LH  = 3'd4;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_q, exc_d;
  logic        accept;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic        unused_addr;

  assign mem_A       = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];

  assign rsp_valid = (state_q == FULL);
  assign req_ready = !(rsp_valid && wb_stall) && !flush;
  assign accept    = req_valid && req_ready;

`ifdef DM_LOAD_ADDR_EXC_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_type)
      T_LBU, T_LB: misaligned = 1'b0;
      T_LHU, T_LH: misaligned = req_addr[0];
      default:     misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end
  assign rsp_exc = exc_q;
`else
  assign misaligned = 1'b0;
  assign rsp_exc    = 1'b0;
`endif

  // Flush outranks both accept and the stall hold; a drained register also drops its exception.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    off_d   = off_q;
    type_d  = type_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    if (flush) begin
      state_d = EMPTY;
      exc_d   = 1'b0;
    end else if (accept) begin
      state_d = FULL;
      word_d  = mem_RData;
      off_d   = req_addr[1:0];
      type_d  = req_type;
      pc_d    = req_pc;
      exc_d   = misaligned;
    end else if (state_q == FULL && !wb_stall) begin
      state_d = EMPTY;
      exc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      word_q  <= '0;
      off_q   <= '0;
      type_q  <= '0;
      pc_q    <= RST_PC;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      off_q   <= off_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    byte_sel = word_q[7:0];
    case (off_q)
      2'd0: byte_sel = word_q[7:0];
      2'd1: byte_sel = word_q[15:8];
      2'd2: byte_sel = word_q[23:16];
      2'd3: byte_sel = word_q[31:24];
      default: byte_sel = word_q[7:0];
    endcase
    half_sel = off_q[1] ? word_q[31:16] : word_q[15:0];
  end

  always_comb begin
    ext_data = word_q;
    case (type_q)
      T_LBU:   ext_data = {24'h0, byte_sel};
      T_LB:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      T_LHU:   ext_data = {16'h0, half_sel};
      T_LH:    ext_data = {{16{half_sel[15]}}, half_sel};
      default: ext_data = word_q;
    endcase
  end

  assign rsp_data = rsp_exc ? '0 : ext_data;
  assign rsp_pc   = pc_q;

endmodule
